// File: rtl/ysyx_23060061_mc_core.sv
// rtl/ysyx_23060061_mc_core.sv - multi-cycle RV32I/RV32E integer core (FETCH/WAIT/EXEC/HALT)
module ysyx_23060061_mc_core #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000,
    parameter int                NREG     = 32,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ifu_req_valid,
    input  logic              ifu_req_ready,
    output logic [XLEN-1:0]   ifu_req_addr,
    input  logic              ifu_rsp_valid,
    input  logic [31:0]       ifu_rsp_inst,
    output logic [XLEN-1:0]   pc,
    output logic              retire,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              halted,
    output logic              illegal,
    output logic [XLEN-1:0]   halt_code
);
    localparam int        IDX_W  = $clog2(NREG);
    localparam logic [5:0] NREG_L = 6'(NREG);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;
    state_t state, state_nx;

    logic [31:0]     ir;
    logic [XLEN-1:0] regs [NREG];

    logic [6:0] opcode, funct7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    logic [XLEN-1:0] imm_i, imm_u, imm_j, rs1_val, rs2_val;
    assign imm_i   = {{20{ir[31]}}, ir[31:20]};
    assign imm_u   = {ir[31:12], 12'b0};
    assign imm_j   = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1[IDX_W-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2[IDX_W-1:0]];

    logic            legal, wen, is_ebreak, use_rs1, use_rs2, use_rd, bad_idx, ill;
    logic [XLEN-1:0] wdata, next_pc;

    always_comb begin
        legal     = 1'b0;
        wen       = 1'b0;
        is_ebreak = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        wdata     = '0;
        next_pc   = pc + XLEN'(4);
        case (opcode)
            7'b0010011: if (funct3 == 3'b000) begin
                legal = 1'b1; wen = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
                wdata = rs1_val + imm_i;
            end
            7'b0110011: if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
                legal = 1'b1; wen = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                wdata = funct7[5] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
            end
            7'b0110111: begin
                legal = 1'b1; wen = 1'b1; use_rd = 1'b1;
                wdata = imm_u;
            end
            7'b0010111: begin
                legal = 1'b1; wen = 1'b1; use_rd = 1'b1;
                wdata = pc + imm_u;
            end
            7'b1101111: begin
                legal = 1'b1; wen = 1'b1; use_rd = 1'b1;
                wdata   = pc + XLEN'(4);
                next_pc = pc + imm_j;
            end
            7'b1100111: if (funct3 == 3'b000) begin
                legal = 1'b1; wen = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
                wdata   = pc + XLEN'(4);
                next_pc = (rs1_val + imm_i) & ~XLEN'(1);
            end
            7'b1110011: if (ir == 32'h0010_0073) begin
                legal = 1'b1; is_ebreak = 1'b1;
            end
            default: ;
        endcase
    end

    // Only the register fields an instruction actually uses can make it illegal on RV32E
    assign bad_idx = (use_rs1 && ({1'b0, rs1} >= NREG_L)) ||
                     (use_rs2 && ({1'b0, rs2} >= NREG_L)) ||
                     (use_rd  && ({1'b0, rd}  >= NREG_L));
    assign ill = !legal || bad_idx;

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: if (ifu_req_ready) state_nx = S_WAIT;
            S_WAIT:  if (ifu_rsp_valid) state_nx = S_EXEC;
            S_EXEC:  state_nx = (ill || is_ebreak) ? S_HALT : S_FETCH;
            default: state_nx = S_HALT;
        endcase
    end

    assign ifu_req_valid = (state == S_FETCH);
    assign ifu_req_addr  = pc;
    assign retire        = (state == S_EXEC) && !ill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            retire_cnt <= '0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            halt_code  <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            if (state == S_WAIT && ifu_rsp_valid) ir <= ifu_rsp_inst;
            if (state == S_EXEC) begin
                if (ill) begin
                    illegal   <= 1'b1;
                    halted    <= 1'b1;
                    halt_code <= regs[10];
                end else begin
                    retire_cnt <= retire_cnt + CNT_W'(1);
                    if (is_ebreak) begin
                        halted    <= 1'b1;
                        halt_code <= regs[10];
                    end else begin
                        pc <= next_pc;
                    end
                    if (wen && rd != 5'd0) regs[rd[IDX_W-1:0]] <= wdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060061_mc_core.sv
// tb/tb_ysyx_23060061_mc_core.sv - scoreboard bench for ysyx_23060061_mc_core (RV32I and RV32E instances)
module tb_ysyx_23060061_mc_core;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, retire, halted, illegal;
    logic [31:0] ifu_req_addr, ifu_rsp_inst, pc, halt_code;
    logic [2:0]  retire_cnt;

    logic        e_req_valid, e_req_ready, e_rsp_valid, e_retire, e_halted, e_illegal;
    logic [31:0] e_req_addr, e_rsp_inst, e_pc, e_halt_code;
    logic [2:0]  e_retire_cnt;

    ysyx_23060061_mc_core #(.XLEN(32), .RESET_PC(RPC), .NREG(32), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
        .pc(pc), .retire(retire), .retire_cnt(retire_cnt),
        .halted(halted), .illegal(illegal), .halt_code(halt_code)
    );

    ysyx_23060061_mc_core #(.XLEN(32), .RESET_PC(RPC), .NREG(16), .CNT_W(3)) dut_e (
        .clk(clk), .rst(rst),
        .ifu_req_valid(e_req_valid), .ifu_req_ready(e_req_ready), .ifu_req_addr(e_req_addr),
        .ifu_rsp_valid(e_rsp_valid), .ifu_rsp_inst(e_rsp_inst),
        .pc(e_pc), .retire(e_retire), .retire_cnt(e_retire_cnt),
        .halted(e_halted), .illegal(e_illegal), .halt_code(e_halt_code)
    );

    int total = 0;
    int bad = 0;

    typedef struct { logic [31:0] pc; logic [2:0] cnt; } exp_t;
    exp_t       sb[$];
    exp_t       mon_e;
    logic [2:0] cnt_model;
    int         cyc, last_ret_cyc, ret_seen;
    bit         chk_pend = 1'b0;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Each retire pops the expectation pushed when its instruction was driven; pc/count checked after the EXEC edge
    always @(negedge clk) begin
        if (chk_pend) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_retire: pc=%h cnt=%0d required=no retire", pc, retire_cnt);
            end else begin
                mon_e = sb.pop_front();
                if (pc !== mon_e.pc) begin
                    bad++;
                    $display("FAIL sb_pc: got %h required %h", pc, mon_e.pc);
                end
                total++;
                if (retire_cnt !== mon_e.cnt) begin
                    bad++;
                    $display("FAIL sb_retire_cnt: got %0d required %0d", retire_cnt, mon_e.cnt);
                end
            end
        end
        chk_pend = 1'b0;
        if (!rst && retire === 1'b1) begin
            chk_pend     = 1'b1;
            ret_seen++;
            last_ret_cyc = cyc;
        end
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, 3'b000, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = '0;
        e_req_ready = 1'b0; e_rsp_valid = 1'b0; e_rsp_inst = '0;
        repeat (2) @(negedge clk);
        sb.delete();
        cnt_model = '0;
        rst = 1'b0;
    endtask

    task automatic step(input int rdly, input int sdly, input logic [31:0] inst,
                        input logic [31:0] exp_pc, input bit exp_retire);
        int n;
        logic [31:0] a0;
        n = 0;
        while (ifu_req_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (ifu_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL req_timeout: req_valid=%b required 1 within 20 cycles", ifu_req_valid);
            return;
        end
        a0 = ifu_req_addr;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            total++;
            if (ifu_req_valid !== 1'b1 || ifu_req_addr !== a0) begin
                bad++;
                $display("FAIL req_hold: valid=%b addr=%h required 1 %h", ifu_req_valid, ifu_req_addr, a0);
            end
        end
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        for (int i = 0; i < sdly; i++) begin
            total++;
            if (ifu_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL wait_req_valid: got %b required 0", ifu_req_valid);
            end
            @(negedge clk);
        end
        if (exp_retire) begin
            cnt_model = cnt_model + 3'd1;
            sb.push_back('{pc: exp_pc, cnt: cnt_model});
        end
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = inst;
        @(negedge clk);
        ifu_rsp_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = '0;
        e_req_ready = 1'b0; e_rsp_valid = 1'b0; e_rsp_inst = '0;
        @(negedge clk);
        total++;
        if (pc !== RPC || retire_cnt !== 3'd0 || halted !== 1'b0 || illegal !== 1'b0 ||
            halt_code !== 32'd0 || retire !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: pc=%h cnt=%0d h=%b i=%b hc=%h r=%b required %h 0 0 0 0 0",
                     pc, retire_cnt, halted, illegal, halt_code, retire, RPC);
        end
        do_reset();
        total++;
        if (ifu_req_valid !== 1'b1 || ifu_req_addr !== RPC) begin
            bad++;
            $display("FAIL reset_first_req: valid=%b addr=%h required 1 %h", ifu_req_valid, ifu_req_addr, RPC);
        end
    endtask

    task automatic test_addi();
        do_reset();
        step(0, 0, enc_i(12'd5, 5'd0, 5'd1, 7'h13), RPC + 32'd4, 1'b1);
        total++;
        if (last_ret_cyc !== 2) begin
            bad++;
            $display("FAIL addi_retire_cyc1: got %0d required 2", last_ret_cyc);
        end
        step(0, 0, enc_i(12'hFFF, 5'd1, 5'd1, 7'h13), RPC + 32'd8, 1'b1);
        total++;
        if (last_ret_cyc !== 5) begin
            bad++;
            $display("FAIL addi_retire_cyc2: got %0d required 5", last_ret_cyc);
        end
        total++;
        if (dut.regs[1] !== 32'd4) begin
            bad++;
            $display("FAIL addi_x1: got %h required 4", dut.regs[1]);
        end
    endtask

    task automatic test_ebreak();
        int req_hits;
        do_reset();
        step(0, 0, {20'h12345, 5'd10, 7'h37}, RPC + 32'd4, 1'b1);
        step(0, 0, enc_i(12'h678, 5'd10, 5'd10, 7'h13), RPC + 32'd8, 1'b1);
        step(0, 0, 32'h0010_0073, RPC + 32'd8, 1'b1);
        total++;
        if (halted !== 1'b1 || illegal !== 1'b0 || halt_code !== 32'h1234_5678) begin
            bad++;
            $display("FAIL ebreak_status: h=%b i=%b hc=%h required 1 0 12345678", halted, illegal, halt_code);
        end
        req_hits = 0;
        for (int i = 0; i < 10; i++) begin
            ifu_req_ready = 1'b1;
            @(negedge clk);
            if (ifu_req_valid !== 1'b0) req_hits++;
        end
        ifu_req_ready = 1'b0;
        total++;
        if (req_hits != 0 || pc !== RPC + 32'd8) begin
            bad++;
            $display("FAIL halt_frozen: req_cycles=%0d pc=%h required 0 %h", req_hits, pc, RPC + 32'd8);
        end
    endtask

    task automatic test_jump();
        do_reset();
        step(0, 0, enc_j(21'd16, 5'd1), RPC + 32'h10, 1'b1);
        total++;
        if (dut.regs[1] !== RPC + 32'd4 || ifu_req_addr !== RPC + 32'h10) begin
            bad++;
            $display("FAIL jal: x1=%h addr=%h required %h %h", dut.regs[1], ifu_req_addr, RPC + 32'd4, RPC + 32'h10);
        end
        step(0, 0, enc_i(12'd1, 5'd1, 5'd0, 7'h67), RPC + 32'd4, 1'b1);
        total++;
        if (ifu_req_addr !== RPC + 32'd4 || dut.regs[0] !== 32'd0) begin
            bad++;
            $display("FAIL jalr: addr=%h x0=%h required %h 0", ifu_req_addr, dut.regs[0], RPC + 32'd4);
        end
    endtask

    task automatic test_alu();
        do_reset();
        step(0, 0, {20'h00001, 5'd2, 7'h17}, RPC + 32'd4, 1'b1);
        step(0, 0, enc_i(12'd3, 5'd0, 5'd3, 7'h13), RPC + 32'd8, 1'b1);
        step(0, 0, enc_r(7'h00, 5'd3, 5'd2, 5'd5), RPC + 32'hC, 1'b1);
        step(0, 0, enc_r(7'h20, 5'd2, 5'd3, 5'd4), RPC + 32'h10, 1'b1);
        total++;
        if (dut.regs[2] !== 32'h8000_1000 || dut.regs[5] !== 32'h8000_1003 || dut.regs[4] !== 32'h7FFF_F003) begin
            bad++;
            $display("FAIL alu: x2=%h x5=%h x4=%h required 80001000 80001003 7ffff003",
                     dut.regs[2], dut.regs[5], dut.regs[4]);
        end
    endtask

    task automatic test_stall();
        int r0;
        do_reset();
        r0 = ret_seen;
        step(4, 3, enc_i(12'd7, 5'd0, 5'd0, 7'h13), RPC + 32'd4, 1'b1);
        total++;
        if (ret_seen - r0 != 1 || dut.regs[0] !== 32'd0) begin
            bad++;
            $display("FAIL stall: retires=%0d x0=%h required 1 0", ret_seen - r0, dut.regs[0]);
        end
    endtask

    task automatic test_illegal();
        int r0;
        do_reset();
        step(0, 0, enc_i(12'd9, 5'd0, 5'd10, 7'h13), RPC + 32'd4, 1'b1);
        r0 = ret_seen;
        step(0, 0, enc_r(7'h01, 5'd1, 5'd1, 5'd1), 32'd0, 1'b0);
        total++;
        if (illegal !== 1'b1 || halted !== 1'b1 || halt_code !== 32'd9 || pc !== RPC + 32'd4 ||
            retire_cnt !== 3'd1 || ret_seen != r0 || ifu_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL illegal_enc: i=%b h=%b hc=%h pc=%h cnt=%0d ret=%0d rv=%b required 1 1 9 %h 1 0 0",
                     illegal, halted, halt_code, pc, retire_cnt, ret_seen - r0, ifu_req_valid, RPC + 32'd4);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 8; i++)
            step(0, 0, enc_i(12'd1, 5'd1, 5'd1, 7'h13), RPC + 32'(4 * (i + 1)), 1'b1);
        total++;
        if (retire_cnt !== 3'd0 || dut.regs[1] !== 32'd8) begin
            bad++;
            $display("FAIL cnt_wrap: cnt=%0d x1=%h required 0 8", retire_cnt, dut.regs[1]);
        end
    endtask

    task automatic test_rv32e();
        do_reset();
        e_req_ready = 1'b1; @(negedge clk); e_req_ready = 1'b0;
        e_rsp_valid = 1'b1; e_rsp_inst = enc_i(12'd1, 5'd0, 5'd5, 7'h13); @(negedge clk); e_rsp_valid = 1'b0;
        total++;
        if (e_retire !== 1'b1) begin
            bad++;
            $display("FAIL e_retire_legal: got %b required 1", e_retire);
        end
        @(negedge clk);
        e_req_ready = 1'b1; @(negedge clk); e_req_ready = 1'b0;
        e_rsp_valid = 1'b1; e_rsp_inst = enc_i(12'd1, 5'd0, 5'd20, 7'h13); @(negedge clk); e_rsp_valid = 1'b0;
        total++;
        if (e_retire !== 1'b0) begin
            bad++;
            $display("FAIL e_retire_illegal: got %b required 0", e_retire);
        end
        @(negedge clk);
        total++;
        if (e_illegal !== 1'b1 || e_halted !== 1'b1 || e_pc !== RPC + 32'd4 || e_retire_cnt !== 3'd1 ||
            e_req_valid !== 1'b0 || dut_e.regs[5] !== 32'd1) begin
            bad++;
            $display("FAIL e_bad_index: i=%b h=%b pc=%h cnt=%0d rv=%b x5=%h required 1 1 %h 1 0 1",
                     e_illegal, e_halted, e_pc, e_retire_cnt, e_req_valid, dut_e.regs[5], RPC + 32'd4);
        end
        do_reset();
        e_rsp_valid = 1'b1; e_rsp_inst = 32'h0010_0073; @(negedge clk); e_rsp_valid = 1'b0;
        total++;
        if (e_req_valid !== 1'b1 || e_halted !== 1'b0) begin
            bad++;
            $display("FAIL e_stale_rsp: rv=%b h=%b required 1 0", e_req_valid, e_halted);
        end
        e_req_ready = 1'b1; @(negedge clk); e_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (e_pc !== RPC || e_retire_cnt !== 3'd0 || e_halted !== 1'b0 || e_illegal !== 1'b0 ||
            e_halt_code !== 32'd0 || e_retire !== 1'b0 || e_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL e_mid_wait_reset: pc=%h cnt=%0d h=%b i=%b hc=%h r=%b rv=%b required %h 0 0 0 0 0 1",
                     e_pc, e_retire_cnt, e_halted, e_illegal, e_halt_code, e_retire, e_req_valid, RPC);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_ebreak();
        test_jump();
        test_alu();
        test_stall();
        test_illegal();
        test_wrap();
        test_rv32e();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
